// File: rtl/cg_tlb_fa_refill.sv
// cg_tlb_fa_refill: fully-associative Sv39-style TLB with one-outstanding PTW refill and selective flush
module cg_tlb_fa_refill #(
    parameter int VADDR_WIDTH  = 39,
    parameter int PADDR_WIDTH  = 56,
    parameter int OFFSET_WIDTH = 12,
    parameter int ASID_WIDTH   = 16,
    parameter int ENTRY_NUM    = 16,
    parameter int LEVELS       = 3,
    parameter int VPN_SEG      = 9,
    parameter int VPN_W        = VADDR_WIDTH - OFFSET_WIDTH,
    parameter int PPN_W        = PADDR_WIDTH - OFFSET_WIDTH,
    parameter int LVL_W        = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_vaddr_valid,
    input  logic [VADDR_WIDTH-1:0] i_vaddr,
    input  logic [ASID_WIDTH-1:0]  i_asid,
    output logic                   o_paddr_valid,
    output logic [PADDR_WIDTH-1:0] o_paddr,
    output logic                   o_tlb_miss,
    output logic                   o_miss_req_valid,
    output logic [VPN_W-1:0]       o_miss_req_vpn,
    output logic [ASID_WIDTH-1:0]  o_miss_req_asid,
    input  logic                   i_miss_req_ready,
    input  logic                   i_refill_valid,
    input  logic [PPN_W-1:0]       i_refill_ppn,
    input  logic [LVL_W-1:0]       i_refill_level,
    input  logic                   i_refill_global,
    input  logic                   i_refill_fault,
    output logic                   o_fault,
    input  logic                   i_flush_valid,
    input  logic                   i_flush_vaddr_en,
    input  logic                   i_flush_asid_en,
    input  logic [VADDR_WIDTH-1:0] i_flush_vaddr,
    input  logic [ASID_WIDTH-1:0]  i_flush_asid,
    output logic                   o_busy
);
    localparam int IW = $clog2(ENTRY_NUM);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t state, state_n;
    logic drop;
    logic [IW-1:0] rr;
    logic [ENTRY_NUM-1:0] e_val, e_glb;
    logic [VPN_W-1:0] e_vpn [ENTRY_NUM];
    logic [ASID_WIDTH-1:0] e_asid [ENTRY_NUM];
    logic [PPN_W-1:0] e_ppn [ENTRY_NUM];
    logic [LVL_W-1:0] e_lvl [ENTRY_NUM];

    logic [ENTRY_NUM-1:0] lk_m, rq_m, fl_m;
    logic [IW-1:0] hit_idx, rq_idx, inv_idx, victim;
    logic hit, use_rr, install;
    logic [VPN_W-1:0] lk_vpn, fl_vpn;
    logic [PPN_W-1:0] lo;
    logic [PADDR_WIDTH-1:0] pa;
    logic unused_ok;

    // VPN bits at or above the entry's level take part in the compare; lower bits pass through
    function automatic logic [VPN_W-1:0] hi_mask(input logic [LVL_W-1:0] l);
        for (int b = 0; b < VPN_W; b++) hi_mask[b] = (b >= int'(l) * VPN_SEG);
    endfunction

    assign lk_vpn    = i_vaddr[VADDR_WIDTH-1:OFFSET_WIDTH];
    assign fl_vpn    = i_flush_vaddr[VADDR_WIDTH-1:OFFSET_WIDTH];
    assign unused_ok = ^i_flush_vaddr[OFFSET_WIDTH-1:0];

    always_comb begin
        lk_m    = '0;
        rq_m    = '0;
        fl_m    = '0;
        hit_idx = '0;
        rq_idx  = '0;
        inv_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            lk_m[i] = e_val[i] & (e_glb[i] | (e_asid[i] == i_asid))
                    & (((e_vpn[i] ^ lk_vpn) & hi_mask(e_lvl[i])) == '0);
            rq_m[i] = e_val[i] & (e_glb[i] | (e_asid[i] == o_miss_req_asid))
                    & (((e_vpn[i] ^ o_miss_req_vpn) & hi_mask(e_lvl[i])) == '0);
            fl_m[i] = (~i_flush_vaddr_en | (((e_vpn[i] ^ fl_vpn) & hi_mask(e_lvl[i])) == '0))
                    & (~i_flush_asid_en | ((e_asid[i] == i_flush_asid) & ~e_glb[i]));
            if (lk_m[i]) hit_idx = IW'(i);
            if (rq_m[i]) rq_idx = IW'(i);
            if (!e_val[i]) inv_idx = IW'(i);
        end
    end

    assign hit     = |lk_m;
    assign use_rr  = ~|rq_m & (&e_val);
    assign victim  = |rq_m ? rq_idx : use_rr ? rr : inv_idx;
    assign install = (state == S_WAIT) & i_refill_valid & ~i_refill_fault & ~drop & ~i_flush_valid;
    assign lo      = {{(PPN_W - VPN_W){1'b0}}, ~hi_mask(e_lvl[hit_idx])};
    assign pa      = {(e_ppn[hit_idx] & ~lo) | ({{(PPN_W - VPN_W){1'b0}}, lk_vpn} & lo),
                      i_vaddr[OFFSET_WIDTH-1:0]};

    always_comb begin
        state_n = state == S_IDLE ? ((i_vaddr_valid & ~hit) ? S_REQ : S_IDLE) :
                  state == S_REQ  ? (i_miss_req_ready ? S_WAIT : S_REQ) :
                  state == S_WAIT ? (i_refill_valid ? S_IDLE : S_WAIT) : S_IDLE;
        o_miss_req_valid = state == S_REQ;
        o_busy = state != S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state           <= S_IDLE;
            drop            <= 1'b0;
            rr              <= '0;
            e_val           <= '0;
            o_miss_req_vpn  <= '0;
            o_miss_req_asid <= '0;
            o_paddr_valid   <= 1'b0;
            o_tlb_miss      <= 1'b0;
            o_paddr         <= '0;
            o_fault         <= 1'b0;
        end else begin
            state         <= state_n;
            drop          <= (state_n != S_IDLE) & (drop | ((state != S_IDLE) & i_flush_valid));
            o_paddr_valid <= i_vaddr_valid & hit;
            o_tlb_miss    <= i_vaddr_valid & ~hit;
            o_fault       <= (state == S_WAIT) & i_refill_valid & i_refill_fault;
            if (i_vaddr_valid & hit) o_paddr <= pa;
            if ((state == S_IDLE) & i_vaddr_valid & ~hit) begin
                o_miss_req_vpn  <= lk_vpn;
                o_miss_req_asid <= i_asid;
            end
            if (install & use_rr) rr <= rr + 1'b1;
            if (i_flush_valid) e_val <= e_val & ~fl_m;
            if (install) e_val[victim] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (install) begin
            e_vpn[victim]  <= o_miss_req_vpn;
            e_asid[victim] <= o_miss_req_asid;
            e_ppn[victim]  <= i_refill_ppn;
            e_lvl[victim]  <= i_refill_level;
            e_glb[victim]  <= i_refill_global;
        end
    end
endmodule

// File: tb/tb_cg_tlb_fa_refill.sv
// tb_cg_tlb_fa_refill: directed bench for the FA TLB, refill FSM, replacement and flushes
module tb_cg_tlb_fa_refill;
    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_vaddr_valid = 1'b0;
    logic [38:0] i_vaddr = '0;
    logic [15:0] i_asid = '0;
    logic        o_paddr_valid;
    logic [55:0] o_paddr;
    logic        o_tlb_miss;
    logic        o_miss_req_valid;
    logic [26:0] o_miss_req_vpn;
    logic [15:0] o_miss_req_asid;
    logic        i_miss_req_ready = 1'b0;
    logic        i_refill_valid = 1'b0;
    logic [43:0] i_refill_ppn = '0;
    logic [1:0]  i_refill_level = '0;
    logic        i_refill_global = 1'b0;
    logic        i_refill_fault = 1'b0;
    logic        o_fault;
    logic        i_flush_valid = 1'b0;
    logic        i_flush_vaddr_en = 1'b0;
    logic        i_flush_asid_en = 1'b0;
    logic [38:0] i_flush_vaddr = '0;
    logic [15:0] i_flush_asid = '0;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    cg_tlb_fa_refill dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_vaddr_valid(i_vaddr_valid), .i_vaddr(i_vaddr), .i_asid(i_asid),
        .o_paddr_valid(o_paddr_valid), .o_paddr(o_paddr), .o_tlb_miss(o_tlb_miss),
        .o_miss_req_valid(o_miss_req_valid), .o_miss_req_vpn(o_miss_req_vpn),
        .o_miss_req_asid(o_miss_req_asid), .i_miss_req_ready(i_miss_req_ready),
        .i_refill_valid(i_refill_valid), .i_refill_ppn(i_refill_ppn),
        .i_refill_level(i_refill_level), .i_refill_global(i_refill_global),
        .i_refill_fault(i_refill_fault), .o_fault(o_fault),
        .i_flush_valid(i_flush_valid), .i_flush_vaddr_en(i_flush_vaddr_en),
        .i_flush_asid_en(i_flush_asid_en), .i_flush_vaddr(i_flush_vaddr),
        .i_flush_asid(i_flush_asid), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [38:0] va(input logic [26:0] vpn, input logic [11:0] off);
        return {vpn, off};
    endfunction

    task automatic do_reset();
        i_rstn = 1'b0;
        i_vaddr_valid = 1'b0;
        i_miss_req_ready = 1'b0;
        i_refill_valid = 1'b0;
        i_flush_valid = 1'b0;
        step();
        step();
        i_rstn = 1'b1;
    endtask

    task automatic lookup(input logic [38:0] a, input logic [15:0] asid);
        i_vaddr_valid = 1'b1;
        i_vaddr = a;
        i_asid = asid;
        step();
        i_vaddr_valid = 1'b0;
    endtask

    task automatic ready();
        i_miss_req_ready = 1'b1;
        step();
        i_miss_req_ready = 1'b0;
    endtask

    task automatic refill(input logic [43:0] ppn, input logic [1:0] lvl, input logic g, input logic f);
        i_refill_valid = 1'b1;
        i_refill_ppn = ppn;
        i_refill_level = lvl;
        i_refill_global = g;
        i_refill_fault = f;
        step();
        i_refill_valid = 1'b0;
        i_refill_fault = 1'b0;
    endtask

    task automatic flush(input logic ve, input logic ae, input logic [38:0] a, input logic [15:0] asid);
        i_flush_valid = 1'b1;
        i_flush_vaddr_en = ve;
        i_flush_asid_en = ae;
        i_flush_vaddr = a;
        i_flush_asid = asid;
        step();
        i_flush_valid = 1'b0;
    endtask

    task automatic walk(input logic [26:0] vpn, input logic [15:0] asid, input logic [43:0] ppn,
                        input logic [1:0] lvl, input logic g);
        lookup(va(vpn, 12'h0), asid);
        chk("walk_miss", o_tlb_miss, 1);
        chk("walk_req_vpn", o_miss_req_vpn, vpn);
        ready();
        refill(ppn, lvl, g, 1'b0);
    endtask

    initial begin
        // 1: reset state and a base-page walk
        do_reset();
        chk("rst_pv", o_paddr_valid, 0);
        chk("rst_miss", o_tlb_miss, 0);
        chk("rst_req", o_miss_req_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_fault", o_fault, 0);
        chk("rst_paddr", o_paddr, 0);
        lookup(39'h12345678, 16'd1);
        chk("t1_miss", o_tlb_miss, 1);
        chk("t1_pv", o_paddr_valid, 0);
        chk("t1_req", o_miss_req_valid, 1);
        chk("t1_vpn", o_miss_req_vpn, 27'h12345);
        chk("t1_asid", o_miss_req_asid, 1);
        chk("t1_busy", o_busy, 1);
        ready();
        chk("t1_wait_req", o_miss_req_valid, 0);
        chk("t1_wait_busy", o_busy, 1);
        refill(44'hABCDE, 2'd0, 1'b0, 1'b0);
        chk("t1_idle", o_busy, 0);
        lookup(39'h12345678, 16'd1);
        chk("t1_hit", o_paddr_valid, 1);
        chk("t1_paddr", o_paddr, 56'hABCDE678);
        chk("t1_nomiss", o_tlb_miss, 0);

        // 2: superpages
        walk(27'h40000, 16'd1, 44'h40200, 2'd1, 1'b0);
        lookup(39'h400AB123, 16'd1);
        chk("t2_l1_hit", o_paddr_valid, 1);
        chk("t2_l1_paddr", o_paddr, 56'h402AB123);
        walk(27'h4000000, 16'd1, 44'hC0000, 2'd2, 1'b0);
        lookup(va(27'h4012345, 12'hABC), 16'd1);
        chk("t2_l2_hit", o_paddr_valid, 1);
        chk("t2_l2_paddr", o_paddr, 56'hD2345ABC);

        // 3: fill all entries then round-robin replacement
        do_reset();
        for (int k = 0; k < 16; k++) walk(27'h100 + 27'(k), 16'd1, 44'h200 + 44'(k), 2'd0, 1'b0);
        walk(27'h200, 16'd1, 44'h300, 2'd0, 1'b0);
        walk(27'h201, 16'd1, 44'h301, 2'd0, 1'b0);
        lookup(va(27'h102, 12'h034), 16'd1);
        chk("t3_keep_hit", o_paddr_valid, 1);
        chk("t3_keep_paddr", o_paddr, 56'h202034);
        lookup(va(27'h200, 12'h005), 16'd1);
        chk("t3_new0_paddr", o_paddr, 56'h300005);
        lookup(va(27'h201, 12'h006), 16'd1);
        chk("t3_new1_paddr", o_paddr, 56'h301006);
        lookup(va(27'h100, 12'h0), 16'd1);
        chk("t3_evict0_miss", o_tlb_miss, 1);
        lookup(va(27'h101, 12'h0), 16'd1);
        chk("t3_evict1_miss", o_tlb_miss, 1);
        chk("t3_req_stable", o_miss_req_vpn, 27'h100);

        // 4: global / ASID / address / full flushes
        do_reset();
        walk(27'h300, 16'd2, 44'h500, 2'd0, 1'b1);
        walk(27'h301, 16'd2, 44'h501, 2'd0, 1'b0);
        walk(27'h302, 16'd3, 44'h502, 2'd0, 1'b0);
        lookup(va(27'h300, 12'h011), 16'd5);
        chk("t4_glb_hit", o_paddr_valid, 1);
        chk("t4_glb_paddr", o_paddr, 56'h500011);
        flush(1'b0, 1'b1, '0, 16'd2);
        lookup(va(27'h300, 12'h011), 16'd2);
        chk("t4_asid_keep_g", o_paddr_valid, 1);
        lookup(va(27'h302, 12'h011), 16'd3);
        chk("t4_asid_keep_b", o_paddr, 56'h502011);
        lookup(va(27'h301, 12'h011), 16'd2);
        chk("t4_asid_kill_a", o_tlb_miss, 1);
        flush(1'b1, 1'b0, va(27'h300, 12'h0), '0);
        lookup(va(27'h300, 12'h0), 16'd2);
        chk("t4_va_kill_g", o_tlb_miss, 1);
        chk("t4_req_hold", o_miss_req_vpn, 27'h301);
        lookup(va(27'h302, 12'h0), 16'd3);
        chk("t4_va_keep_b", o_paddr_valid, 1);
        flush(1'b0, 1'b0, '0, '0);
        lookup(va(27'h302, 12'h0), 16'd3);
        chk("t4_all_kill_b", o_tlb_miss, 1);
        ready();
        refill(44'h9AA, 2'd0, 1'b0, 1'b0);
        chk("t4_drop_idle", o_busy, 0);
        lookup(va(27'h301, 12'h0), 16'd2);
        chk("t4_drop_miss", o_tlb_miss, 1);

        // 5: flush during WAIT, faulted refill, same-cycle flush+refill
        do_reset();
        lookup(va(27'h777, 12'h0AB), 16'd4);
        ready();
        flush(1'b1, 1'b0, va(27'h999, 12'h0), '0);
        chk("t5_wait_busy", o_busy, 1);
        refill(44'h888, 2'd0, 1'b0, 1'b0);
        chk("t5_drop_idle", o_busy, 0);
        lookup(va(27'h777, 12'h0AB), 16'd4);
        chk("t5_drop_miss", o_tlb_miss, 1);
        ready();
        refill(44'h888, 2'd0, 1'b0, 1'b1);
        chk("t5_fault", o_fault, 1);
        chk("t5_fault_idle", o_busy, 0);
        step();
        chk("t5_fault_pulse", o_fault, 0);
        lookup(va(27'h777, 12'h0AB), 16'd4);
        chk("t5_fault_miss", o_tlb_miss, 1);
        ready();
        i_flush_valid = 1'b1;
        i_flush_vaddr_en = 1'b1;
        i_flush_asid_en = 1'b0;
        i_flush_vaddr = va(27'h999, 12'h0);
        refill(44'h888, 2'd0, 1'b0, 1'b0);
        i_flush_valid = 1'b0;
        lookup(va(27'h777, 12'h0AB), 16'd4);
        chk("t5_same_miss", o_tlb_miss, 1);
        ready();
        refill(44'h888, 2'd0, 1'b0, 1'b0);
        lookup(va(27'h777, 12'h0AB), 16'd4);
        chk("t5_install_hit", o_paddr_valid, 1);
        chk("t5_install_paddr", o_paddr, 56'h8880AB);

        // 6: stalled request, hit-under-miss, async reset mid-walk
        do_reset();
        walk(27'h555, 16'd1, 44'h666, 2'd0, 1'b0);
        lookup(va(27'h123, 12'h0), 16'd1);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                lookup(va(27'h124, 12'h0), 16'd1);
                chk("t6_second_miss", o_tlb_miss, 1);
            end else step();
            chk("t6_req_hold", o_miss_req_valid, 1);
            chk("t6_vpn_hold", o_miss_req_vpn, 27'h123);
        end
        ready();
        chk("t6_wait", o_miss_req_valid, 0);
        lookup(va(27'h555, 12'hABC), 16'd1);
        chk("t6_hum_hit", o_paddr_valid, 1);
        chk("t6_hum_paddr", o_paddr, 56'h666ABC);
        chk("t6_hum_busy", o_busy, 1);
        #2 i_rstn = 1'b0;
        #1;
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_req", o_miss_req_valid, 0);
        chk("t6_rst_pv", o_paddr_valid, 0);
        step();
        i_rstn = 1'b1;
        refill(44'h777, 2'd0, 1'b0, 1'b0);
        chk("t6_late_busy", o_busy, 0);
        chk("t6_late_fault", o_fault, 0);
        lookup(va(27'h123, 12'h0), 16'd1);
        chk("t6_req_again", o_miss_req_valid, 1);
        #2 i_rstn = 1'b0;
        #1;
        chk("t6_rst_req_drop", o_miss_req_valid, 0);
        step();
        i_rstn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
